// File: rtl/wired0_defines.sv
// Shared backend definitions: CDB payload layout, source indices and ROB bank select.
package wired0_defines;

   localparam int ROB_ID_W    = 6;
   localparam int DATA_W      = 32;
   localparam int EXC_CODE_W  = 5;
   localparam int CDB_SRC_CNT = 4;
   localparam int CDB_BANKS   = 2;

   // Index into the per-bank boost vector.
   localparam int BOOST_LSU = 0;
   localparam int BOOST_MDU = 1;

   typedef enum logic [1:0] {
      SRC_ALU0 = 2'd0,
      SRC_ALU1 = 2'd1,
      SRC_LSU  = 2'd2,
      SRC_MDU  = 2'd3
   } cdb_src_e;

   typedef struct packed {
      logic [ROB_ID_W-1:0]   rid;
      logic [DATA_W-1:0]     data;
      logic                  exc_valid;
      logic [EXC_CODE_W-1:0] exc_code;
   } pipeline_cdb_t;

   function automatic logic rob_bank(input logic [ROB_ID_W-1:0] rid);
      return rid[0];
   endfunction

endpackage

// File: rtl/wired_cdb_bank_arb.sv
// One-hot grant for a single ROB bank: boosted LSU, then boosted MDU, then fixed index priority.
module wired_cdb_bank_arb
   import wired0_defines::*;
(
   input  logic [CDB_SRC_CNT-1:0] req,
   input  logic [1:0]             boost,
   output logic [CDB_SRC_CNT-1:0] grant
);

   logic found;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      grant = '0;
      found = 1'b0;
      if (boost[BOOST_LSU] && req[SRC_LSU]) begin
         grant[SRC_LSU] = 1'b1;
      end else if (boost[BOOST_MDU] && req[SRC_MDU]) begin
         grant[SRC_MDU] = 1'b1;
      end else begin
         for (int s = 0; s < CDB_SRC_CNT; s++) begin
            if (req[s] && !found) begin
               grant[s] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/wired_cdb_arbiter.sv
// Merges ALU0/ALU1/LSU/MDU results onto the two-slot registered CDB; slot k serves ROB bank k.
module wired_cdb_arbiter
   import wired0_defines::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  pipeline_cdb_t [1:0]            alu_payload_i,
   input  logic [1:0]                     alu_valid_i,
   output logic [1:0]                     alu_ready_o,
   input  pipeline_cdb_t                  lsu_payload_i,
   input  logic                           lsu_valid_i,
   output logic                           lsu_ready_o,
   input  pipeline_cdb_t                  mdu_payload_i,
   input  logic                           mdu_valid_i,
   output logic                           mdu_ready_o,
   input  logic                           flush_i,
   output pipeline_cdb_t [CDB_BANKS-1:0]  cdb_o,
   output logic [CDB_BANKS-1:0]           cdb_valid_o
);

   logic [CDB_SRC_CNT-1:0]                valid;
   pipeline_cdb_t                         payload [CDB_SRC_CNT];
   logic [CDB_BANKS-1:0][CDB_SRC_CNT-1:0] req;
   logic [CDB_BANKS-1:0][CDB_SRC_CNT-1:0] grant;
   logic [CDB_SRC_CNT-1:0]                granted;
   logic [CDB_SRC_CNT-1:0]                ready;
   pipeline_cdb_t                         win_payload [CDB_BANKS];
   logic [CNT_W-1:0]                      lsu_wait;
   logic [CNT_W-1:0]                      mdu_wait;
   logic [CNT_W-1:0]                      lsu_wait_next;
   logic [CNT_W-1:0]                      mdu_wait_next;
   logic [1:0]                            boost;

   assign valid = {mdu_valid_i, lsu_valid_i, alu_valid_i};

   always_comb begin
      payload[SRC_ALU0] = alu_payload_i[0];
      payload[SRC_ALU1] = alu_payload_i[1];
      payload[SRC_LSU]  = lsu_payload_i;
      payload[SRC_MDU]  = mdu_payload_i;
   end

   // Requests are masked while reset is sampled so nothing is accepted into a dropped slot.
   always_comb begin
      req = '0;
      for (int b = 0; b < CDB_BANKS; b++) begin
         for (int s = 0; s < CDB_SRC_CNT; s++) begin
            req[b][s] = rst_n && valid[s] && (rob_bank(payload[s].rid) == 1'(b));
         end
      end
   end

   assign boost[BOOST_LSU] = (lsu_wait == CNT_W'(STARVE_LIMIT));
   assign boost[BOOST_MDU] = (mdu_wait == CNT_W'(STARVE_LIMIT));

   for (genvar b = 0; b < CDB_BANKS; b++) begin : g_bank
      wired_cdb_bank_arb u_arb (
         .req   (req[b]),
         .boost (boost),
         .grant (grant[b])
      );
   end

   always_comb begin
      granted = '0;
      for (int b = 0; b < CDB_BANKS; b++) begin
         granted = granted | grant[b];
         win_payload[b] = '0;
         for (int s = 0; s < CDB_SRC_CNT; s++) begin
            if (grant[b][s]) win_payload[b] = payload[s];
         end
      end
   end

   // A flush drains every valid source so the producers can discard in one cycle.
   assign ready       = (rst_n && flush_i) ? valid : granted;
   assign alu_ready_o = ready[1:0];
   assign lsu_ready_o = ready[SRC_LSU];
   assign mdu_ready_o = ready[SRC_MDU];

   always_comb begin
      lsu_wait_next = lsu_wait;
      mdu_wait_next = mdu_wait;
      if (flush_i || granted[SRC_LSU] || !valid[SRC_LSU]) lsu_wait_next = '0;
      else if (!boost[BOOST_LSU])                          lsu_wait_next = lsu_wait + 1'b1;
      if (flush_i || granted[SRC_MDU] || !valid[SRC_MDU]) mdu_wait_next = '0;
      else if (!boost[BOOST_MDU])                          mdu_wait_next = mdu_wait + 1'b1;
   end

   // NOTE: reset is synchronous, so it lives inside the clocked block and is sampled like data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lsu_wait    <= '0;
         mdu_wait    <= '0;
         cdb_valid_o <= '0;
         cdb_o       <= '0;
      end else begin
         lsu_wait <= lsu_wait_next;
         mdu_wait <= mdu_wait_next;
         for (int b = 0; b < CDB_BANKS; b++) begin
            cdb_valid_o[b] <= (|grant[b]) && !flush_i;
            if (|grant[b]) cdb_o[b] <= win_payload[b];
         end
      end
   end

endmodule
